// File: rtl/cv32e40p_mult_ft_ctrl_if.sv
// Multiply-completion handshake between the EX stage and the multiplier fault controller.
// Signals:
//   mult_done_i              voted multiplier result valid this cycle
//   err_a_i/err_b_i/err_c_i  per-replica OR of voter disagreement flags
//   stall_o                  hold EX; voted result must not be committed
//   reissue_o                one-cycle request to replay the multiply
// Modports: slave = controller side, master = pipeline/multiplier side.
interface cv32e40p_mult_ft_ctrl_if;
    logic mult_done_i;
    logic err_a_i;
    logic err_b_i;
    logic err_c_i;
    logic stall_o;
    logic reissue_o;

    modport slave (
        input  mult_done_i,
        input  err_a_i,
        input  err_b_i,
        input  err_c_i,
        output stall_o,
        output reissue_o
    );

    modport master (
        output mult_done_i,
        output err_a_i,
        output err_b_i,
        output err_c_i,
        input  stall_o,
        input  reissue_o
    );
endinterface

// File: rtl/cv32e40p_mult_ft_ctrl.sv
// Fault-management controller for the triplicated multiplier.
// Classifies each multiply completion as clean, corrected (one replica disagrees) or
// uncorrectable (two or more disagree), keeps saturating per-replica error counters, flags
// replicas as permanently faulty at FAULT_THR, and sequences bounded stall+reissue retries,
// ending in a sticky uncorrectable state once MAX_RETRY reissues have failed.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   bus (slave)       mult_done_i, err_a/b/c_i in; stall_o, reissue_o out
//   clear_i           clears counters, sticky flags and the FAIL state
//   err_cnt_a/b/c_o   per-replica error counters
//   fault_replica_o   sticky permanent-fault flags {c, b, a}
//   uncorrectable_o   sticky, retry budget exhausted
//   irq_o             one-cycle pulse on any 0->1 edge of fault_replica_o or uncorrectable_o
// Optional feature: define CV32E40P_MULT_FT_TIMEOUT_EN to fail after TIMEOUT cycles in WAIT
// without a completion.
module cv32e40p_mult_ft_ctrl #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned FAULT_THR = 16,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    cv32e40p_mult_ft_ctrl_if.slave bus,
    input  logic                   clear_i,
    output logic [CNT_W-1:0]       err_cnt_a_o,
    output logic [CNT_W-1:0]       err_cnt_b_o,
    output logic [CNT_W-1:0]       err_cnt_c_o,
    output logic [2:0]             fault_replica_o,
    output logic                   uncorrectable_o,
    output logic                   irq_o
);

    typedef enum logic [1:0] {StIdle, StReissue, StWait, StFail} state_e;

    state_e                  r_state;
    logic [3:0]              r_retry;
    logic [2:0][CNT_W-1:0]   r_cnt;
    logic [2:0]              r_fault;
    logic                    r_unc;
    logic                    r_irq;

    logic [2:0]              w_err;
    logic                    w_multi;
    logic                    w_unc;
    logic                    w_corr;
    logic                    w_tmo;
    logic                    w_to_fail;
    logic                    w_stall;
    logic [2:0][CNT_W-1:0]   w_cnt_d;
    logic [2:0]              w_fault_d;

    assign w_err   = {bus.err_c_i, bus.err_b_i, bus.err_a_i};
    // Two or more flags: a bitwise voter with no majority marks every input.
    assign w_multi = (w_err[0] & w_err[1]) | (w_err[0] & w_err[2]) | (w_err[1] & w_err[2]);
    assign w_unc   = bus.mult_done_i & w_multi;
    assign w_corr  = bus.mult_done_i & (^w_err) & ~w_multi & (r_state != StFail);

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_cnt_d[k] = r_cnt[k];
            if (w_corr && w_err[k] && (r_cnt[k] != {CNT_W{1'b1}})) begin
                w_cnt_d[k] = r_cnt[k] + 1'b1;
            end
            w_fault_d[k] = r_fault[k] | (w_cnt_d[k] >= CNT_W'(FAULT_THR));
        end
    end

`ifdef CV32E40P_MULT_FT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo;

    // A completion in the timeout cycle takes precedence.
    assign w_tmo = (r_state == StWait) && !bus.mult_done_i && (r_tmo == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear_i || (r_state != StWait)) begin
            r_tmo <= '0;
        end else if (!w_tmo) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    // No timeout: WAIT holds until a completion arrives; TIMEOUT has no effect.
    assign w_tmo = 1'b0 & (TIMEOUT != 0);
`endif

    assign w_to_fail = (r_state == StWait) &&
                       ((w_unc && (r_retry == 4'(MAX_RETRY))) || w_tmo);

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_state <= StIdle;
            r_retry <= '0;
            r_cnt   <= '0;
            r_fault <= '0;
            r_unc   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_d;
            r_fault <= w_fault_d;
            r_irq   <= (|(w_fault_d & ~r_fault)) | (w_to_fail & ~r_unc);
            if (w_to_fail) begin
                r_unc <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (w_unc) begin
                        r_retry <= 4'd1;
                        r_state <= StReissue;
                    end
                end
                StReissue: r_state <= StWait;
                StWait: begin
                    if (w_to_fail) begin
                        r_retry <= '0;
                        r_state <= StFail;
                    end else if (bus.mult_done_i) begin
                        if (w_unc) begin
                            r_retry <= r_retry + 4'd1;
                            r_state <= StReissue;
                        end else begin
                            r_retry <= '0;
                            r_state <= StIdle;
                        end
                    end
                end
                StFail: r_state <= StFail;
                default: r_state <= StIdle;
            endcase
        end
    end

    // Stall must rise in the detect cycle itself, so it is decoded from state and inputs.
    always_comb begin
        w_stall = 1'b0;
        unique case (r_state)
            StIdle:    w_stall = w_unc & ~clear_i;
            StReissue: w_stall = 1'b1;
            StWait:    w_stall = clear_i | ~bus.mult_done_i | w_multi;
            StFail:    w_stall = 1'b0;
        endcase
    end

    assign bus.stall_o     = w_stall;
    assign bus.reissue_o   = (r_state == StReissue);
    assign err_cnt_a_o     = r_cnt[0];
    assign err_cnt_b_o     = r_cnt[1];
    assign err_cnt_c_o     = r_cnt[2];
    assign fault_replica_o = r_fault;
    assign uncorrectable_o = r_unc;
    assign irq_o           = r_irq;

endmodule

// File: tb/tb_cv32e40p_mult_ft_ctrl.sv
// Scoreboard bench for cv32e40p_mult_ft_ctrl. Two instances share the stimulus: one with
// CNT_W=8/FAULT_THR=16, one with CNT_W=4/FAULT_THR=12 for saturation. The driver computes the
// expected outputs of every cycle from a behavioural model and queues them; a monitor on the
// falling edge pops and compares.
module tb_cv32e40p_mult_ft_ctrl;
    localparam int MAX_RETRY = 2;
    localparam int TIMEOUT   = 8;

    logic clk = 1'b0;
    logic rst;
    logic clear_i;
    always #5 clk = ~clk;

    cv32e40p_mult_ft_ctrl_if bus0 ();
    cv32e40p_mult_ft_ctrl_if bus1 ();

    logic [7:0] ca0, cb0, cc0;
    logic [3:0] ca1, cb1, cc1;
    logic [2:0] f0, f1;
    logic       u0, u1, irq0, irq1;

    cv32e40p_mult_ft_ctrl #(
        .CNT_W(8), .FAULT_THR(16), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave), .clear_i(clear_i),
        .err_cnt_a_o(ca0), .err_cnt_b_o(cb0), .err_cnt_c_o(cc0),
        .fault_replica_o(f0), .uncorrectable_o(u0), .irq_o(irq0)
    );

    cv32e40p_mult_ft_ctrl #(
        .CNT_W(4), .FAULT_THR(12), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .clear_i(clear_i),
        .err_cnt_a_o(ca1), .err_cnt_b_o(cb1), .err_cnt_c_o(cc1),
        .fault_replica_o(f1), .uncorrectable_o(u1), .irq_o(irq1)
    );

    typedef struct packed {
        logic       chk;
        logic       stall;
        logic       reissue;
        logic [7:0] ca;
        logic [7:0] cb;
        logic [7:0] cc;
        logic [2:0] fault;
        logic       unc;
        logic       irq;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state per instance: errors seen, flags, and the retry episode in progress.
    int m_cnt[2][3];
    bit m_fault[2][3];
    bit m_unc[2];
    bit m_irq[2];
    bit m_failed[2];
    int m_tries[2];       // reissues issued in the current episode, 0 when none
    bit m_reissue[2];     // reissue request due this cycle
    int m_wait[2];        // cycles spent waiting for the replayed result

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int m, input bit d, input bit a, input bit b, input bit c,
                              input bit clr, input bit r, output exp_t e);
        int  n;
        int  cmax;
        int  thr;
        int  k;
        bit  waiting;
        bit  idle;
        bit  fail_now;
        cmax    = (m == 0) ? 255 : 15;
        thr     = (m == 0) ? 16 : 12;
        n       = int'(a) + int'(b) + int'(c);
        waiting = !m_failed[m] && m_tries[m] > 0 && !m_reissue[m];
        idle    = !m_failed[m] && m_tries[m] == 0;
        e.chk     = !r;
        e.ca      = 8'(m_cnt[m][0]);
        e.cb      = 8'(m_cnt[m][1]);
        e.cc      = 8'(m_cnt[m][2]);
        e.fault   = {m_fault[m][2], m_fault[m][1], m_fault[m][0]};
        e.unc     = m_unc[m];
        e.irq     = m_irq[m];
        e.reissue = m_reissue[m];
        if (m_failed[m])       e.stall = 1'b0;
        else if (m_reissue[m]) e.stall = 1'b1;
        else if (waiting)      e.stall = clr || !(d && n < 2);
        else                   e.stall = d && n >= 2 && !clr;

        if (r || clr) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[m][i]   = 0;
                m_fault[m][i] = 1'b0;
            end
            m_unc[m] = 0; m_irq[m] = 0; m_failed[m] = 0;
            m_tries[m] = 0; m_reissue[m] = 0; m_wait[m] = 0;
        end else begin
            fail_now = 1'b0;
            if (d && n == 1 && !m_failed[m]) begin
                k = a ? 0 : (b ? 1 : 2);
                if (m_cnt[m][k] < cmax) m_cnt[m][k]++;
            end
            if (m_reissue[m]) begin
                m_reissue[m] = 1'b0;
                m_wait[m]    = 0;
            end else if (waiting) begin
                if (d) begin
                    if (n < 2) begin
                        m_tries[m] = 0;
                    end else if (m_tries[m] < MAX_RETRY) begin
                        m_tries[m]++;
                        m_reissue[m] = 1'b1;
                    end else begin
                        fail_now   = 1'b1;
                        m_tries[m] = 0;
                    end
                end
`ifdef CV32E40P_MULT_FT_TIMEOUT_EN
                else begin
                    m_wait[m]++;
                    if (m_wait[m] == TIMEOUT) begin
                        fail_now   = 1'b1;
                        m_tries[m] = 0;
                    end
                end
`endif
            end else if (idle && d && n >= 2) begin
                m_tries[m]   = 1;
                m_reissue[m] = 1'b1;
            end
            m_irq[m] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (!m_fault[m][i] && m_cnt[m][i] >= thr) begin
                    m_fault[m][i] = 1'b1;
                    m_irq[m]      = 1'b1;
                end
            end
            if (fail_now) begin
                m_failed[m] = 1'b1;
                if (!m_unc[m]) m_irq[m] = 1'b1;
                m_unc[m] = 1'b1;
            end
        end
    endtask

    task automatic cyc(input bit d, input bit a, input bit b, input bit c,
                       input bit clr, input bit r);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        clear_i = clr;
        bus0.mult_done_i = d; bus0.err_a_i = a; bus0.err_b_i = b; bus0.err_c_i = c;
        bus1.mult_done_i = d; bus1.err_a_i = a; bus1.err_b_i = b; bus1.err_c_i = c;
        model_step(0, d, a, b, c, clr, r, e);
        q0.push_back(e);
        model_step(1, d, a, b, c, clr, r, e);
        q1.push_back(e);
    endtask

    task automatic compare(input string tag, input exp_t e, input logic st, input logic re,
                           input int ca, input int cb, input int cc, input logic [2:0] f,
                           input logic u, input logic irq);
        if (e.chk) begin
            chk({tag, ".stall"}, int'(st), int'(e.stall));
            chk({tag, ".reissue"}, int'(re), int'(e.reissue));
            chk({tag, ".cnt_a"}, ca, int'(e.ca));
            chk({tag, ".cnt_b"}, cb, int'(e.cb));
            chk({tag, ".cnt_c"}, cc, int'(e.cc));
            chk({tag, ".fault"}, int'(f), int'(e.fault));
            chk({tag, ".unc"}, int'(u), int'(e.unc));
            chk({tag, ".irq"}, int'(irq), int'(e.irq));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            compare("dut0", e, bus0.stall_o, bus0.reissue_o, int'(ca0), int'(cb0), int'(cc0),
                    f0, u0, irq0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            compare("dut1", e, bus1.stall_o, bus1.reissue_o, int'(ca1), int'(cb1), int'(cc1),
                    f1, u1, irq1);
        end
    end

    initial begin
        bit d, a, b, c, clr, r;
        int pat;
        rst = 1'b1;
        clear_i = 1'b0;
        bus0.mult_done_i = 0; bus0.err_a_i = 0; bus0.err_b_i = 0; bus0.err_c_i = 0;
        bus1.mult_done_i = 0; bus1.err_a_i = 0; bus1.err_b_i = 0; bus1.err_c_i = 0;
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);

        // Corrected counting on b, then saturation on c.
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Recovery on the first retry.
        cyc(1, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Exhaustion, then a completion in FAIL and a clear colliding with a done.
        cyc(1, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Waiting with no completion: timeout when enabled, otherwise a held stall.
        cyc(1, 1, 1, 1, 0, 0);
        repeat (20) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Reset in the middle of a retry.
        cyc(1, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            d   = ($urandom_range(0, 9) < 4);
            pat = $urandom_range(0, 9);
            a = 0; b = 0; c = 0;
            if (pat >= 6 && pat <= 8) begin
                case ($urandom_range(0, 2))
                    0: a = 1;
                    1: b = 1;
                    default: c = 1;
                endcase
            end else if (pat == 9) begin
                a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
            end
            clr = ($urandom_range(0, 79) == 0);
            r   = ($urandom_range(0, 299) == 0);
            cyc(d, a, b, c, clr, r);
        end
        cyc(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
